// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
// The sweep fill value is computed here so every instance agrees on it.
package reg_file_mp_pkg;

  typedef enum logic {
    RF_IDLE = 1'b0,
    RF_INIT = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W_DEF = 32;
  localparam int RF_ADDR_W_DEF = 5;
  localparam int RF_MAX_W      = 64;

  // mode 0 fills with zeros, any other mode fills with the entry index
  function automatic logic [RF_MAX_W-1:0] rf_init_value(input logic [RF_MAX_W-1:0] idx,
                                                        input int                  mode);
    return (mode != 0) ? idx : '0;
  endfunction

endpackage

// File: rtl/reg_file_mp_read_port.sv
// One combinational read port: busy blanking, zero-register override,
// write-first bypass, then the stored entry.
module rf_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              busy,
  output logic [DATA_W-1:0] rd_data
);

  always_comb begin
    rd_data = mem_data;
    if (busy) begin
      rd_data = '0;
    end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
      rd_data = '0;
    end else if (byp_en && (rd_addr == wr_addr)) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised GPR file with NUM_RD combinational read ports, sequenced
// re-initialisation sweep and a registered debug read port.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W_DEF,
  parameter int ADDR_W    = RF_ADDR_W_DEF,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 1,
  parameter int INIT_MODE = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     init_req,
  output logic                     busy,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dbg_q, dbg_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] init_val;
  logic              byp_en;

  assign busy     = (state_q == RF_INIT);
  assign byp_en   = wr_en && (state_q == RF_IDLE);
  assign dbg_data = dbg_q;
  assign init_val = DATA_W'(rf_init_value(RF_MAX_W'(cnt_q), INIT_MODE));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    case (state_q)
      RF_IDLE: begin
        mem_we = wr_en;
        if (init_req) begin
          state_d = RF_INIT;
          cnt_d   = '0;
        end
      end
      RF_INIT: begin
        // init_req is deliberately ignored here; the sweep never restarts itself
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = init_val;
        cnt_d     = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = RF_IDLE;
        end
      end
      default: state_d = RF_INIT;
    endcase
    if (((ZERO_REG != 0) && (mem_waddr == '0)) || !reset) begin
      mem_we = 1'b0;
    end
  end

  always_comb begin
    dbg_d = mem_q[dbg_addr];
    if ((ZERO_REG != 0) && (dbg_addr == '0)) begin
      dbg_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
      dbg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dbg_q   <= dbg_d;
    end
  end

  // Storage is never reset; the sweep is what makes every entry defined
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .rd_addr (rd_addr[k*ADDR_W +: ADDR_W]),
      .mem_data(mem_q[rd_addr[k*ADDR_W +: ADDR_W]]),
      .byp_en  (byp_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy),
      .rd_data (rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised and directed bench for reg_file_mp against a behavioural model
// that tracks the array contents and the remaining sweep length.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              init_req;
  logic              busy;
  logic [AW-1:0]     dbg_addr;
  logic [DW-1:0]     dbg_data;

  reg_file_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .INIT_MODE(1)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .init_req(init_req),
    .busy    (busy),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  // Reference model
  logic [DW-1:0] ref_mem [DEPTH];
  int            sweep_left = 0;
  logic [DW-1:0] dbg_m = '0;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (sweep_left > 0) return '0;
    if (a == 0) return '0;
    if (wr_en && a == wr_addr) return wr_data;
    return ref_mem[a];
  endfunction

  // Apply what the spec says happens at one rising edge, using current inputs
  task automatic model_edge();
    int pos;
    if (!reset) begin
      sweep_left = DEPTH;
      dbg_m = '0;
    end else begin
      dbg_m = (dbg_addr == 0) ? '0 : ref_mem[dbg_addr];
      if (sweep_left > 0) begin
        pos = DEPTH - sweep_left;
        if (pos != 0) ref_mem[pos] = DW'(pos);
        sweep_left--;
      end else begin
        if (wr_en && wr_addr != 0) ref_mem[wr_addr] = wr_data;
        if (init_req) sweep_left = DEPTH;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_busy"}, DW'(busy), DW'(sweep_left > 0));
    chk({tag, "_dbg"}, dbg_data, dbg_m);
    for (int k = 0; k < NR; k++)
      chk($sformatf("%s_rd%0d", tag, k), rd_data[k*DW +: DW], exp_rd(rd_addr[k*AW +: AW]));
  endtask

  task automatic cyc(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; init_req = 1'b0; reset = 1'b1;
  endtask

  // Runs until busy drops, returning the number of edges taken (bounded)
  task automatic run_sweep(input string tag, output int n);
    n = 0;
    while (busy && n < 100) begin
      cyc(tag);
      n++;
    end
  endtask

  initial begin
    int n;
    reset = 1'b0; wr_en = 1'b0; init_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; dbg_addr = '0;

    // Reset and first sweep
    cyc("rst");
    chk("rst_busy", DW'(busy), 32'd1);
    chk("rst_dbg", dbg_data, 32'd0);
    reset = 1'b1;
    run_sweep("sw0", n);
    chk("sweep_len_reset", DW'(n), 32'd32);
    rd_addr = {5'd31, 5'd7};
    #1;
    chk("init7", rd_data[31:0], 32'd7);
    chk("init31", rd_data[63:32], 32'd31);
    rd_addr = {5'd0, 5'd0};
    #1;
    chk("init0", rd_data[31:0], 32'd0);

    // Bypass on both ports
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd5, 5'd5};
    #1;
    chk("byp_p0", rd_data[31:0], 32'hDEADBEEF);
    chk("byp_p1", rd_data[63:32], 32'hDEADBEEF);
    cyc("byp");
    wr_en = 1'b0;
    #1;
    chk("post_p0", rd_data[31:0], 32'hDEADBEEF);
    chk("post_p1", rd_data[63:32], 32'hDEADBEEF);

    // Zero register
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr = '0; dbg_addr = 5'd0;
    #1;
    chk("zero_byp_p0", rd_data[31:0], 32'd0);
    chk("zero_byp_p1", rd_data[63:32], 32'd0);
    cyc("zw");
    wr_en = 1'b0;
    cyc("zr");
    chk("zero_p0", rd_data[31:0], 32'd0);
    chk("zero_dbg", dbg_data, 32'd0);

    // Debug latency
    dbg_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    cyc("dbgN");
    chk("dbg_old", dbg_data, 32'd9);
    wr_en = 1'b0;
    cyc("dbgN1");
    chk("dbg_new", dbg_data, 32'h55);

    // Write during sweep is dropped, reads blank while busy
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77; init_req = 1'b1;
    cyc("req");
    init_req = 1'b0; wr_data = 32'hAA; rd_addr = {5'd3, 5'd3};
    #1;
    chk("busy_rd0", rd_data[31:0], 32'd0);
    chk("busy_flag", DW'(busy), 32'd1);
    run_sweep("sw1", n);
    chk("sweep_len_req", DW'(n), 32'd32);
    wr_en = 1'b0;
    #1;
    chk("drop_a3", rd_data[31:0], 32'd3);

    // Reset mid-sweep, plus a second request that must not extend it
    init_req = 1'b1;
    cyc("req2");
    init_req = 1'b0;
    for (int i = 0; i < 10; i++) cyc("pre");
    reset = 1'b0;
    cyc("mrst");
    reset = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      init_req = (n == 5);
      cyc("sw2");
      n++;
    end
    init_req = 1'b0;
    chk("sweep_len_midrst", DW'(n), 32'd32);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_addr  = AW'($urandom_range(0, DEPTH - 1));
      wr_data  = $urandom;
      init_req = ($urandom_range(0, 59) == 0);
      dbg_addr = AW'($urandom_range(0, DEPTH - 1));
      rd_addr  = ($urandom_range(0, 3) == 0) ? {wr_addr, wr_addr}
                                             : NR*AW'($urandom);
      #1;
      check_all("rnd_pre");
      cyc("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
